// File: rtl/countdown_run_if.sv
// Control and display bundle between the time-setter stage and the countdown core.
// The setter drives run/preset/edit inputs; the core returns display and status.
interface countdown_run_if;
   logic        go;
   logic [31:0] set_val;
   logic [3:0]  edit_state;
   logic [31:0] disp;
   logic        running;
   logic        done;
   logic        alarm;

   modport master (
      output go, set_val, edit_state,
      input  disp, running, done, alarm
   );

   modport slave (
      input  go, set_val, edit_state,
      output disp, running, done, alarm
   );
endinterface

// File: rtl/countdown_run.sv
// HH:MM:SS BCD countdown with pause, one-cycle expiry pulse and a timed alarm.
// The value is held as six BCD nibbles; separator nibbles exist only on the display bus.
module countdown_run #(
   parameter int unsigned TICK_DIV  = 100000000,
   parameter int unsigned ALARM_SEC = 10
) (
   input logic            clk,
   input logic            rst_n,
   countdown_run_if.slave bus
);
   // state | meaning
   // IDLE  | value follows clamped preset, waiting for a go rising edge
   // RUN   | prescaler counting, one-second decrements on wrap
   // PAUSE | value and prescaler frozen, waiting for go or an edit request
   // DONE  | expired, shows 00:00:00, alarm timed by prescaler ticks
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   localparam int unsigned   PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned   AW         = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic          ALARM_EN   = (ALARM_SEC != 0);

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? max : d;
   endfunction

   function automatic logic [23:0] clamp_preset(input logic [23:0] v);
      return {clamp_digit(v[23:20], 4'd9), clamp_digit(v[19:16], 4'd9),
              clamp_digit(v[15:12], 4'd5), clamp_digit(v[11:8],  4'd9),
              clamp_digit(v[7:4],   4'd5), clamp_digit(v[3:0],   4'd9)};
   endfunction

   // Digit 0 is sec_1; tens of seconds and tens of minutes wrap to 5, the rest to 9.
   // A zero value is left untouched so hours never wrap below 00:00:00.
   function automatic logic [23:0] dec_one_sec(input logic [23:0] v);
      logic [23:0] r;
      logic        borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (borrow) begin
            if (r[i*4 +: 4] != 4'd0) begin
               r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end else begin
               r[i*4 +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
            end
         end
      end
      return (v == 24'd0) ? 24'd0 : r;
   endfunction

   state_t        state_q, state_d;
   logic [23:0]   value_q, value_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [AW-1:0] alm_cnt_q, alm_cnt_d;
   logic          alarm_q, alarm_d;
   logic          done_q, done_d;
   logic          go_q;
   logic          armed_q;

   logic [23:0]   preset_raw;
   logic [23:0]   preset_c;
   logic [23:0]   value_dec;
   logic [PW-1:0] presc_inc;
   logic          tick;
   logic          go_rise;
   logic          go_fall;
   logic          alarm_last;

   assign preset_raw = {bus.set_val[31:24], bus.set_val[19:12], bus.set_val[7:0]};
   assign preset_c   = clamp_preset(preset_raw);
   assign value_dec  = dec_one_sec(value_q);
   assign tick       = (presc_q == PRESC_LAST);
   assign presc_inc  = tick ? '0 : presc_q + PW'(1);
   // armed_q masks the first cycle after reset so a go already high is not an edge
   assign go_rise    = bus.go & ~go_q & armed_q;
   assign go_fall    = ~bus.go & go_q;
   assign alarm_last = ((32'(alm_cnt_q) + 32'd1) >= ALARM_SEC);

   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      presc_d   = presc_q;
      alm_cnt_d = alm_cnt_q;
      alarm_d   = alarm_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            value_d = preset_c;
            presc_d = '0;
            if (go_rise) begin
               if (preset_c != 24'd0) begin
                  state_d = RUN;
               end else begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  alarm_d   = ALARM_EN;
                  alm_cnt_d = '0;
               end
            end
         end
         RUN: begin
            presc_d = presc_inc;
            if (tick) begin
               value_d = value_dec;
               if (value_dec == 24'd0) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  alarm_d   = ALARM_EN;
                  alm_cnt_d = '0;
                  presc_d   = '0;
               end else if (!bus.go) begin
                  state_d = PAUSE;
               end
            end else if (!bus.go) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (bus.go) begin
               state_d = RUN;
            end else if (bus.edit_state != 4'd0) begin
               state_d = IDLE;
               presc_d = '0;
            end
         end
         DONE: begin
            value_d = '0;
            presc_d = presc_inc;
            if (go_fall) begin
               state_d   = IDLE;
               alarm_d   = 1'b0;
               alm_cnt_d = '0;
               presc_d   = '0;
            end else if (tick && alarm_q) begin
               alm_cnt_d = alm_cnt_q + AW'(1);
               if (alarm_last) begin
                  alarm_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            presc_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         value_q   <= '0;
         presc_q   <= '0;
         alm_cnt_q <= '0;
         alarm_q   <= 1'b0;
         done_q    <= 1'b0;
         go_q      <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         presc_q   <= presc_d;
         alm_cnt_q <= alm_cnt_d;
         alarm_q   <= alarm_d;
         done_q    <= done_d;
         go_q      <= bus.go;
         armed_q   <= 1'b1;
      end
   end

   assign bus.disp    = {value_q[23:16], 4'hf, value_q[15:8], 4'hf, value_q[7:0]};
   assign bus.running = (state_q == RUN);
   assign bus.done    = done_q;
   assign bus.alarm   = alarm_q;

endmodule
